// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with 16x oversampling feeding a first-word-fall-through receive FIFO.
// Sticky overflow/frame-error flags; clr_err clears both unless a set event lands the same cycle.
`timescale 1ns/1ps
module uart_rx_fifo #(
   parameter int unsigned OVERSAMPLE_DIV = 36,
   parameter int unsigned FIFO_DEPTH     = 8
) (
   input  logic                          clock,
   input  logic                          reset_n,
   input  logic                          UART_Rx,
   input  logic                          rd_en,
   output logic [7:0]                    rd_data,
   output logic                          empty,
   output logic [$clog2(FIFO_DEPTH):0]   count,
   output logic                          overflow,
   output logic                          frame_err,
   input  logic                          clr_err
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam logic [15:0]   TickMax = 16'(OVERSAMPLE_DIV - 1);
   localparam logic [CW-1:0] Full    = CW'(FIFO_DEPTH);

   localparam logic [1:0] StIdle  = 2'd0;
   localparam logic [1:0] StStart = 2'd1;
   localparam logic [1:0] StData  = 2'd2;
   localparam logic [1:0] StStop  = 2'd3;

   logic          rx_meta_q, rxs_q, rxs_prev_q;
   logic [15:0]   tcnt_q, tcnt_d;
   logic          tick;
   logic [1:0]    state_q, state_d;
   logic [3:0]    scnt_q, scnt_d;
   logic [2:0]    bidx_q, bidx_d;
   logic [7:0]    shreg_q, shreg_d;
   logic          push, ferr_set;
   logic          full, do_push, do_pop;
   logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          overflow_q, overflow_d, frame_err_q, frame_err_d;
   logic [7:0]    mem_q [FIFO_DEPTH];

   assign tick   = (tcnt_q == TickMax);
   assign tcnt_d = tick ? 16'd0 : tcnt_q + 16'd1;

   always_comb begin
      state_d  = state_q;
      scnt_d   = scnt_q;
      bidx_d   = bidx_q;
      shreg_d  = shreg_q;
      push     = 1'b0;
      ferr_set = 1'b0;
      case (state_q)
         StIdle: begin
            if (rxs_prev_q && !rxs_q) begin
               state_d = StStart;
               scnt_d  = 4'd0;
            end
         end
         StStart: begin
            if (tick) begin
               if (scnt_q == 4'd7) begin
                  // A high line at the start-bit midpoint is treated as a glitch.
                  if (!rxs_q) begin
                     state_d = StData;
                     scnt_d  = 4'd0;
                     bidx_d  = 3'd0;
                  end else begin
                     state_d = StIdle;
                  end
               end else begin
                  scnt_d = scnt_q + 4'd1;
               end
            end
         end
         StData: begin
            if (tick) begin
               scnt_d = scnt_q + 4'd1;
               if (scnt_q == 4'd15) begin
                  shreg_d[bidx_q] = rxs_q;
                  bidx_d          = bidx_q + 3'd1;
                  if (bidx_q == 3'd7) begin
                     state_d = StStop;
                     scnt_d  = 4'd0;
                  end
               end
            end
         end
         default: begin
            if (tick) begin
               scnt_d = scnt_q + 4'd1;
               if (scnt_q == 4'd15) begin
                  state_d  = StIdle;
                  push     = rxs_q;
                  ferr_set = !rxs_q;
               end
            end
         end
      endcase
   end

   always_comb begin
      full    = (count_q == Full);
      do_pop  = rd_en && (count_q != '0);
      // A simultaneous pop frees a slot, so a push into a full FIFO still lands.
      do_push = push && (!full || do_pop);
      wptr_d  = do_push ? wptr_q + AW'(1) : wptr_q;
      rptr_d  = do_pop ? rptr_q + AW'(1) : rptr_q;
      count_d = count_q;
      if (do_push && !do_pop) count_d = count_q + CW'(1);
      if (!do_push && do_pop) count_d = count_q - CW'(1);
      overflow_d  = (overflow_q && !clr_err) || (push && full && !do_pop);
      frame_err_d = (frame_err_q && !clr_err) || ferr_set;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rx_meta_q   <= 1'b1;
         rxs_q       <= 1'b1;
         rxs_prev_q  <= 1'b1;
         tcnt_q      <= 16'd0;
         state_q     <= StIdle;
         scnt_q      <= 4'd0;
         bidx_q      <= 3'd0;
         shreg_q     <= 8'h00;
         wptr_q      <= '0;
         rptr_q      <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         rx_meta_q   <= UART_Rx;
         rxs_q       <= rx_meta_q;
         rxs_prev_q  <= rxs_q;
         tcnt_q      <= tcnt_d;
         state_q     <= state_d;
         scnt_q      <= scnt_d;
         bidx_q      <= bidx_d;
         shreg_q     <= shreg_d;
         wptr_q      <= wptr_d;
         rptr_q      <= rptr_d;
         count_q     <= count_d;
         overflow_q  <= overflow_d;
         frame_err_q <= frame_err_d;
      end
   end

   // Storage is not reset; rd_data is masked while empty.
   always_ff @(posedge clock) begin
      if (do_push) mem_q[wptr_q] <= shreg_q;
   end

   assign empty     = (count_q == '0);
   assign count     = count_q;
   assign rd_data   = empty ? 8'h00 : mem_q[rptr_q];
   assign overflow  = overflow_q;
   assign frame_err = frame_err_q;

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter OVERSAMPLE_DIV, default 36, meaning clocks per 16x-oversample tick (legal range 2..65535; 36 gives about 115200 baud at 66 MHz).
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, meaning receive FIFO entries (power of two, 2..64).
REQ-003 SHALL have port clock, input, 1, meaning the single system clock; all logic is on its rising edge.
REQ-004 SHALL have port reset_n, input, 1, meaning the asynchronous, active-low reset.
REQ-005 SHALL have port UART_Rx, input, 1, meaning the serial line (idle high, 8N1, LSB first), asynchronous to clock.
REQ-006 SHALL have port rd_en, input, 1, meaning pop the FIFO head this cycle.
REQ-007 SHALL have port rd_data, output, 8, meaning the FIFO head byte (first-word fall-through).
REQ-008 SHALL have port empty, output, 1, meaning the FIFO holds no bytes.
REQ-009 SHALL have port count, output, clog2(FIFO_DEPTH)+1, meaning the number of bytes held.
REQ-010 SHALL have port overflow, output, 1, meaning sticky: a byte was dropped because the FIFO was full.
REQ-011 SHALL have port frame_err, output, 1, meaning sticky: a stop bit was sampled low.
REQ-012 SHALL have port clr_err, input, 1, meaning clear both sticky flags.

Function
REQ-013 SHALL pass UART_Rx through a 2-flop synchronizer; all decisions use the synchronized value rxs.
REQ-014 SHALL run a free-running tick counter 0..OVERSAMPLE_DIV-1; tick SHALL pulse for one clock when the counter equals OVERSAMPLE_DIV-1, and the counter SHALL then wrap to 0.
REQ-015 SHALL implement FSM states IDLE, START, DATA and STOP, plus a 4-bit sample counter scnt and a 3-bit bit index.
REQ-016 IDLE: on a falling edge of rxs (previous rxs 1, current 0), the FSM SHALL go to START with scnt=0; a low rxs with no falling edge SHALL NOT arm the FSM.
REQ-017 START: on the tick where scnt=7, rxs=0 SHALL go to DATA with scnt=0 and bit index 0; rxs=1 SHALL count as a glitch and return to IDLE with no flag set.
REQ-018 DATA: on each tick where scnt=15, rxs SHALL be shifted into bit[index] (LSB first); after index 7 the FSM SHALL go to STOP with scnt=0.
REQ-019 STOP: on the tick where scnt=15, rxs=1 SHALL issue a push of the assembled byte; rxs=0 SHALL set frame_err and discard the byte. In both cases the FSM SHALL go to IDLE.
REQ-020 scnt SHALL advance only on tick; it SHALL wrap 15->0 in DATA and STOP.
REQ-021 A push SHALL take effect in the clock after the stop-bit sample; empty SHALL fall and count SHALL rise in that same cycle.
REQ-022 A push while the FIFO is full and rd_en=0 SHALL drop the byte, set overflow, and leave the contents and count unchanged.
REQ-023 A push and a pop in the same cycle SHALL succeed at any fill level, including full, leave count unchanged, and not set overflow.
REQ-024 rd_en while empty SHALL be ignored, with no underflow and no pointer change.
REQ-025 rd_data SHALL equal the oldest byte whenever empty=0, and 8'h00 whenever empty=1.
REQ-026 The read and write pointers SHALL wrap modulo FIFO_DEPTH; count SHALL range 0..FIFO_DEPTH.
REQ-027 clr_err SHALL clear overflow and frame_err on the next clock; if a set event occurs in the same cycle, the set SHALL win.
REQ-028 Latency from the stop-bit midpoint to rd_data valid SHALL be exactly 1 clock.

Reset
REQ-029 While reset_n=0, independent of clock: synchronizer flops =1, FSM=IDLE, scnt=0, bit index=0, tick counter=0, pointers=0, count=0, empty=1, rd_data=8'h00, overflow=0, frame_err=0.
REQ-030 Reset asserted mid-frame SHALL abandon the partial byte; after release, the FSM SHALL rearm only on a fresh falling edge.
REQ-031 Reset SHALL NOT need to clear FIFO storage RAM; rd_data masking covers the empty case.

Verification
REQ-032 OVERSAMPLE_DIV=4, send 8'hA5 (bit period 64 clocks) -> 1 clock after the stop midpoint: empty=0, count=1, rd_data=8'hA5; rd_en pulse -> empty=1, rd_data=8'h00.
REQ-033 Send 9 bytes 8'h01..8'h09 with no reads (FIFO_DEPTH=8) -> count=8, overflow=1, pops return 8'h01..8'h08 in order; then clr_err=1 -> overflow=0.
REQ-034 Send 8'h3C with the stop bit held low -> frame_err=1, count=0; line back high, then send 8'h55 -> received 8'h55.
REQ-035 Drive a low pulse of 20 clocks (< 8 ticks at DIV=4) -> FSM returns to IDLE, count=0, no flags set.
REQ-036 With the FIFO full, push and rd_en in the same cycle -> count stays 8, overflow=0, new byte appears at the tail.
REQ-037 Assert reset_n=0 mid-DATA of a byte, release, then send 8'hC3 -> only 8'hC3 is received, count=1.
